ps2_mouse_position: RTL and testbench

Receives the PS/2 mouse serial stream, decodes standard 3-byte stream-mode movement packets, and accumulates an absolute cursor position clamped to the visible 640x480 area. It is the producer side of the `mouse_position_x` / `mouse_position_y` / button interface consumed by the VGA cursor renderer. The block only listens on the PS/2 lines and never drives them. Issuing the host-side enable-reporting command (0xF4) belongs to a separate block.

---
 rtl/ps2_mouse_position.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_mouse_position.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_position.sv
// PS/2 mouse stream receiver: decodes 3-byte movement packets and accumulates a
// clamped absolute cursor position plus button state.
module ps2_mouse_position #(
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] mouse_position_x,
  output logic [15:0] mouse_position_y,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_middle,
  output logic        packet_valid,
  output logic        frame_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] ToLim = CntW'(TIMEOUT_CYCLES);
  localparam logic signed [17:0] XMax = 18'(SCREEN_W - 1);
  localparam logic signed [17:0] YMax = 18'(SCREEN_H - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchronisers; reset high so an idle bus never looks like an edge.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  logic ps2_edge;
  assign ps2_edge = clk_prev_q & ~clk_sync_q;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      byte0_q, byte0_d;
  logic [7:0]      byte1_q, byte1_d;
  logic [15:0]     x_q, x_d;
  logic [15:0]     y_q, y_d;
  logic [2:0]      btn_q, btn_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [CntW-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      byte_idx_q  <= '0;
      byte0_q     <= '0;
      byte1_q     <= '0;
      x_q         <= 16'(SCREEN_W / 2);
      y_q         <= 16'(SCREEN_H / 2);
      btn_q       <= '0;
      pkt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      byte_idx_q  <= byte_idx_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      x_q         <= x_d;
      y_q         <= y_d;
      btn_q       <= btn_d;
      pkt_valid_q <= pkt_valid_d;
      frame_err_q <= frame_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Movement arithmetic; byte 2 is still in the shift register at the stop edge.
  logic signed [17:0] dx, dy, x_sum, y_sum;
  logic [15:0]        x_clamp, y_clamp;

  always_comb begin
    dx    = byte0_q[6] ? 18'sd0 : {{9{byte0_q[4]}}, byte0_q[4], byte1_q};
    dy    = byte0_q[7] ? 18'sd0 : {{9{byte0_q[5]}}, byte0_q[5], shift_q};
    x_sum = $signed({2'b00, x_q}) + dx;
    y_sum = $signed({2'b00, y_q}) - dy;
    if (x_sum < 18'sd0)     x_clamp = '0;
    else if (x_sum > XMax)  x_clamp = XMax[15:0];
    else                    x_clamp = x_sum[15:0];
    if (y_sum < 18'sd0)     y_clamp = '0;
    else if (y_sum > YMax)  y_clamp = YMax[15:0];
    else                    y_clamp = y_sum[15:0];
  end

  logic busy, timeout, frame_good;
  assign busy       = (state_q != StIdle) || (byte_idx_q != 2'd0);
  assign timeout    = !ps2_edge && (to_cnt_q == ToLim) && busy;
  assign frame_good = data_sync_q && (^{shift_q, parity_q});

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    byte_idx_d  = byte_idx_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    x_d         = x_q;
    y_d         = y_q;
    btn_d       = btn_q;
    pkt_valid_d = 1'b0;
    frame_err_d = 1'b0;

    if (ps2_edge)              to_cnt_d = '0;
    else if (to_cnt_q != ToLim) to_cnt_d = to_cnt_q + CntW'(1);
    else                        to_cnt_d = to_cnt_q;

    if (timeout) begin
      state_d     = StIdle;
      byte_idx_d  = 2'd0;
      frame_err_d = 1'b1;
    end else if (ps2_edge) begin
      unique case (state_q)
        StIdle: begin
          if (!data_sync_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = data_sync_q;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (frame_good) begin
            case (byte_idx_q)
              2'd0: begin
                // Bytes without the sync bit are dropped silently.
                if (shift_q[3]) begin
                  byte0_d    = shift_q;
                  byte_idx_d = 2'd1;
                end
              end
              2'd1: begin
                byte1_d    = shift_q;
                byte_idx_d = 2'd2;
              end
              2'd2: begin
                x_d         = x_clamp;
                y_d         = y_clamp;
                btn_d       = {byte0_q[2], byte0_q[1], byte0_q[0]};
                pkt_valid_d = 1'b1;
                byte_idx_d  = 2'd0;
              end
              default: byte_idx_d = 2'd0;
            endcase
          end else begin
            frame_err_d = 1'b1;
            byte_idx_d  = 2'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign mouse_position_x = x_q;
  assign mouse_position_y = y_q;
  assign btn_left         = btn_q[0];
  assign btn_right        = btn_q[1];
  assign btn_middle       = btn_q[2];
  assign packet_valid     = pkt_valid_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_ps2_mouse_position.sv
// Scoreboard bench: stimulus pushes expected packet/error responses, a monitor
// pops and compares them whenever the DUT pulses packet_valid or frame_err.
module tb_ps2_mouse_position;

  localparam int unsigned TimeoutCycles = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] mouse_position_x, mouse_position_y;
  logic        btn_left, btn_right, btn_middle, packet_valid, frame_err;

  ps2_mouse_position #(
    .SCREEN_W      (640),
    .SCREEN_H      (480),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .mouse_position_x(mouse_position_x),
    .mouse_position_y(mouse_position_y),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .btn_middle      (btn_middle),
    .packet_valid    (packet_valid),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int x;
    int y;
    bit l;
    bit r;
    bit m;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (packet_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected pulse: packet_valid=%0b frame_err=%0b, required none",
                 packet_valid, frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          check("err.frame_err", int'(frame_err), 1);
          check("err.packet_valid", int'(packet_valid), 0);
        end else begin
          check("pkt.packet_valid", int'(packet_valid), 1);
          check("pkt.frame_err", int'(frame_err), 0);
          check("pkt.x", int'(mouse_position_x), e.x);
          check("pkt.y", int'(mouse_position_y), e.y);
          check("pkt.btn_left", int'(btn_left), int'(e.l));
          check("pkt.btn_right", int'(btn_right), int'(e.r));
          check("pkt.btn_middle", int'(btn_middle), int'(e.m));
        end
      end
    end
  end

  task automatic push_pkt(input int x, input int y, input bit l, input bit r, input bit m);
    exp_t e;
    e.is_err = 1'b0; e.x = x; e.y = y; e.l = l; e.r = r; e.m = m;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.x = 0; e.y = 0; e.l = 1'b0; e.r = 1'b0; e.m = 1'b0;
    exp_q.push_back(e);
  endtask

  // Device-side frame: data changes while clock is high, host samples on fall.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (20) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (40) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(posedge clk);
    end
    ps2_data = 1'b1;
    repeat (200) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, ".x"}, int'(mouse_position_x), 320);
    check({tag, ".y"}, int'(mouse_position_y), 240);
    check({tag, ".buttons"}, int'({btn_middle, btn_right, btn_left}), 0);
    check({tag, ".pulses"}, int'({packet_valid, frame_err}), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    repeat (10) @(posedge clk);

    push_pkt(330, 235, 1, 0, 0);
    send_pkt(8'h09, 8'h0A, 8'h05);
    wait_drain();

    // Reset mid-packet and mid-frame; the next packet must decode from byte 0.
    send_byte(8'h09);
    send_frame(8'h0A, 1'b0, 4);
    #3 rst = 1'b1;
    repeat (5) @(posedge clk);
    check_reset_state("midreset");
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    check_reset_state("postreset");

    push_pkt(330, 235, 1, 0, 0);
    send_pkt(8'h09, 8'h0A, 8'h05);
    wait_drain();

    push_pkt(74, 235, 0, 0, 0);
    send_pkt(8'h18, 8'h00, 8'h00);
    push_pkt(0, 235, 0, 0, 0);
    send_pkt(8'h18, 8'h00, 8'h00);
    push_pkt(0, 479, 0, 0, 0);
    send_pkt(8'h28, 8'h00, 8'h00);
    wait_drain();

    send_byte(8'h08);
    push_err();
    send_frame(8'h10, 1'b1, 11);
    push_pkt(1, 479, 0, 0, 0);
    send_pkt(8'h08, 8'h01, 8'h00);
    wait_drain();

    send_byte(8'h00);
    push_pkt(1, 479, 0, 1, 0);
    send_pkt(8'h0A, 8'h00, 8'h00);
    wait_drain();

    send_byte(8'h08);
    send_byte(8'h05);
    push_err();
    repeat (TimeoutCycles + 1000) @(posedge clk);
    wait_drain();
    push_pkt(3, 479, 0, 0, 0);
    send_pkt(8'h08, 8'h02, 8'h00);
    wait_drain();

    push_pkt(3, 479, 0, 0, 0);
    send_pkt(8'h48, 8'h7F, 8'h00);
    push_pkt(3, 352, 0, 0, 1);
    send_pkt(8'h0C, 8'h00, 8'h7F);
    push_pkt(2, 353, 0, 0, 1);
    send_pkt(8'h3C, 8'hFF, 8'hFF);
    push_pkt(129, 353, 1, 1, 0);
    send_pkt(8'h0B, 8'h7F, 8'h00);
    wait_drain();

    // Outputs must hold across a long idle gap with no spurious pulses.
    repeat (TimeoutCycles + 500) @(posedge clk);
    @(negedge clk);
    check("hold.x", int'(mouse_position_x), 129);
    check("hold.y", int'(mouse_position_y), 353);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
